hex_display_scanner: RTL and testbench

Sequencer and frame buffer that drives the 4-digit dynamic-scan hex display mux (`DisplaySyn`). It produces the 2-bit scan index at a parameterised dwell rate and holds the active digit, point and enable vectors. It accepts new display contents over a valid/ready handshake, committing them only at frame boundaries so no frame is torn. It also implements per-digit blinking and optional leading-zero blanking.

---
 rtl/hex_display_pkg.sv | 13 +
 rtl/tick_divider.sv | 29 ++
 rtl/hex_display_scanner.sv | 148 ++++++++++++++
 tb/tb_hex_display_scanner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared state encoding and sizing constants for the
// 4-digit hex display scan sequencer.
package hex_display_pkg;

    typedef enum logic {
        S_OFF,
        S_SCAN
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_W     = 2;

endpackage

// File: rtl/tick_divider.sv
// Dwell prescaler: counts 0..TICK_DIV-1 and pulses tick on
// the last count; clear holds it at zero.
module tick_divider #(
    parameter int TICK_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/hex_display_scanner.sv
// Scan sequencer and double-buffered frame store for a 4-digit
// multiplexed hex display, with blinking and zero blanking.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int DIV_W        = 17,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_hexs,
    input  logic [NUM_DIGITS-1:0]   load_point,
    input  logic [NUM_DIGITS-1:0]   load_blink,
    input  logic                    load_lzb,
    output logic [SCAN_W-1:0]       scan,
    output logic [4*NUM_DIGITS-1:0] hexs,
    output logic [NUM_DIGITS-1:0]   point,
    output logic [NUM_DIGITS-1:0]   les,
    output logic                    frame_start
);

    localparam int BLK_W =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST =
        BLK_W'(BLINK_FRAMES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST =
        SCAN_W'(NUM_DIGITS - 1);

    state_t                  r_state;
    logic [SCAN_W-1:0]       r_scan;
    logic [4*NUM_DIGITS-1:0] r_hexs;
    logic [NUM_DIGITS-1:0]   r_point;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic                    r_lzb;
    logic [4*NUM_DIGITS-1:0] r_sh_hexs;
    logic [NUM_DIGITS-1:0]   r_sh_point;
    logic [NUM_DIGITS-1:0]   r_sh_blink;
    logic                    r_sh_lzb;
    logic                    r_pending;
    logic                    r_commit_d;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_adv;
    logic                    w_boundary;
    logic                    w_accept;
    logic                    w_commit;
    logic [NUM_DIGITS-1:0]   w_zero;
    logic [NUM_DIGITS-1:0]   w_blank;

    tick_divider #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (~enable),
        .tick  (w_tick)
    );

    assign w_adv      = enable & (r_state == S_SCAN) & w_tick;
    assign w_boundary = w_adv & (r_scan == SCAN_LAST);
    assign w_accept   = load_valid & ~r_pending;
    // pending lingers one cycle past commit so ready rises late
    assign w_commit   = r_pending & ~r_commit_d &
                        (w_boundary | ~enable);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_OFF;
            r_scan        <= '0;
            r_hexs        <= '0;
            r_point       <= '0;
            r_blink       <= '0;
            r_lzb         <= 1'b0;
            r_sh_hexs     <= '0;
            r_sh_point    <= '0;
            r_sh_blink    <= '0;
            r_sh_lzb      <= 1'b0;
            r_pending     <= 1'b0;
            r_commit_d    <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= enable ? S_SCAN : S_OFF;
            r_frame_start <= w_boundary;
            r_commit_d    <= w_commit;
            if (w_adv) begin
                r_scan <= r_scan + 1'b1;
            end
            if (w_accept) begin
                r_sh_hexs  <= load_hexs;
                r_sh_point <= load_point;
                r_sh_blink <= load_blink;
                r_sh_lzb   <= load_lzb;
            end
            if (r_commit_d) begin
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end
            if (w_commit) begin
                r_hexs  <= r_sh_hexs;
                r_point <= r_sh_point;
                r_blink <= r_sh_blink;
                r_lzb   <= r_sh_lzb;
            end
            if (w_boundary) begin
                if (r_blink_cnt == BLK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_zero  = '0;
        w_blank = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero[i] = (r_hexs[4*i +: 4] == 4'h0);
        end
        if (r_lzb) begin
            w_blank[3] = w_zero[3];
            w_blank[2] = w_zero[3] & w_zero[2];
            w_blank[1] = w_zero[3] & w_zero[2] & w_zero[1];
        end
    end

    assign les = {NUM_DIGITS{enable}} & ~w_blank &
                 ~(r_blink & {NUM_DIGITS{r_blink_phase}});

    assign load_ready  = ~r_pending;
    assign scan        = r_scan;
    assign hexs        = r_hexs;
    assign point       = r_point;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner with
// TICK_DIV=4 and BLINK_FRAMES=2.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_hexs;
    logic [3:0]  load_point;
    logic [3:0]  load_blink;
    logic        load_lzb;
    logic [1:0]  scan;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    logic        frame_start;

    typedef struct {
        logic [15:0] hexs;
        logic [3:0]  point;
        int          acc;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc_n   = 0;

    hex_display_scanner #(
        .TICK_DIV     (4),
        .DIV_W        (3),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_hexs   (load_hexs),
        .load_point  (load_point),
        .load_blink  (load_blink),
        .load_lzb    (load_lzb),
        .scan        (scan),
        .hexs        (hexs),
        .point       (point),
        .les         (les),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h",
                     tag, cyc_n, got, exp);
        end
    endtask

    task automatic cyc();
        sb_t e;
        @(negedge clk);
        cyc_n++;
        if (frame_start && sb.size() > 0 &&
            sb[0].acc < cyc_n - 1) begin
            e = sb.pop_front();
            check("sb_hexs", hexs, e.hexs);
            check("sb_point", point, e.point);
        end
    endtask

    task automatic load(input logic [15:0] h,
                        input logic [3:0] p,
                        input logic [3:0] b,
                        input logic z,
                        input bit acc);
        load_valid = 1'b1;
        load_hexs  = h;
        load_point = p;
        load_blink = b;
        load_lzb   = z;
        if (acc) sb.push_back('{hexs: h, point: p, acc: cyc_n});
    endtask

    function automatic logic ready_exp(input int c);
        return !((c >= 6   && c <= 16)  ||
                 (c >= 42  && c <= 48)  ||
                 (c >= 51  && c <= 64)  ||
                 (c >= 67  && c <= 80)  ||
                 (c >= 176 && c <= 192));
    endfunction

    function automatic logic [3:0] les_exp(input int c);
        if (c < 48)  return 4'hF;
        if (c < 64)  return 4'b0011;
        if (c < 80)  return 4'b0001;
        if (c < 192) return ((c / 32) % 2 == 1) ? 4'b0111 : 4'hF;
        return 4'hF;
    endfunction

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        load_valid = 1'b0;
        load_hexs  = '0;
        load_point = '0;
        load_blink = '0;
        load_lzb   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc_n = 0;
        check("rst_hexs", hexs, 16'h0);
        check("rst_point", point, 4'h0);

        for (int c = 0; c < 202; c++) begin
            check("scan", scan, (c / 4) % 4);
            check("fstart", frame_start, (c > 0 && c % 16 == 0));
            check("ready", load_ready, ready_exp(c));
            check("les", les, les_exp(c));
            if (c == 40)  check("hold_1234", hexs, 16'h1234);
            if (c == 176) check("bnd_wait", hexs, 16'h8421);
            case (c)
                5:   load(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b1);
                10:  load(16'hDEAD, 4'b1111, 4'b1111, 1'b1, 1'b0);
                41:  load(16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b1);
                50:  load(16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b1);
                66:  load(16'h8421, 4'b0010, 4'b1000, 1'b0, 1'b1);
                175: load(16'hABCD, 4'b1111, 4'b0000, 1'b0, 1'b1);
                6, 11, 42, 51, 67, 176: load_valid = 1'b0;
                default: ;
            endcase
            cyc();
        end

        check("dis_scan0", scan, 2'd2);
        enable = 1'b0;
        #1;
        check("dis_les", les, 4'h0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("dis_scan", scan, 2'd2);
            check("dis_les", les, 4'h0);
            check("dis_fs", frame_start, 1'b0);
        end
        enable = 1'b1;
        #1;
        check("en_les", les, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check("en_scan2", scan, 2'd2);
            cyc();
        end
        check("en_scan3", scan, 2'd3);

        load(16'h5555, 4'b1010, 4'b1111, 1'b1, 1'b1);
        cyc();
        load_valid = 1'b0;
        check("pend_ready", load_ready, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc_n = 0;
        check("r2_ready", load_ready, 1'b1);
        check("r2_point", point, 4'h0);
        for (int c = 0; c < 40; c++) begin
            check("r2_scan", scan, (c / 4) % 4);
            check("r2_fs", frame_start, (c > 0 && c % 16 == 0));
            check("r2_hexs", hexs, 16'h0);
            check("r2_les", les, 4'hF);
            cyc();
        end

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
